control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit computer, directly downstream of the instruction register. It consumes the 4-bit opcode the instruction register drives when its output enable is high. It steps a T-state counter through fetch and execute microsteps and drives the 16-bit control word that strobes every register, the memory, the ALU and the program counter. It also gates the instruction register's own load and output enables, and implements conditional jumps from the carry and zero flags.

---
 rtl/control_sequencer_pkg.sv | 57 +++++
 rtl/tstate_counter.sv | 29 ++
 rtl/control_sequencer.sv | 117 +++++++++++
 tb/tb_control_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcodes, control-bit indices and T-state constants
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CB_HLT   = 15;
  localparam int CB_MI    = 14;
  localparam int CB_RI    = 13;
  localparam int CB_RO    = 12;
  localparam int CB_IR_WA = 11;
  localparam int CB_IR_OA = 10;
  localparam int CB_AI    = 9;
  localparam int CB_AO    = 8;
  localparam int CB_EO    = 7;
  localparam int CB_SU    = 6;
  localparam int CB_BI    = 5;
  localparam int CB_OI    = 4;
  localparam int CB_CE    = 3;
  localparam int CB_CO    = 2;
  localparam int CB_J     = 1;
  localparam int CB_FI    = 0;

  localparam logic [15:0] C_HLT   = 16'(1) << CB_HLT;
  localparam logic [15:0] C_MI    = 16'(1) << CB_MI;
  localparam logic [15:0] C_RI    = 16'(1) << CB_RI;
  localparam logic [15:0] C_RO    = 16'(1) << CB_RO;
  localparam logic [15:0] C_IR_WA = 16'(1) << CB_IR_WA;
  localparam logic [15:0] C_IR_OA = 16'(1) << CB_IR_OA;
  localparam logic [15:0] C_AI    = 16'(1) << CB_AI;
  localparam logic [15:0] C_AO    = 16'(1) << CB_AO;
  localparam logic [15:0] C_EO    = 16'(1) << CB_EO;
  localparam logic [15:0] C_SU    = 16'(1) << CB_SU;
  localparam logic [15:0] C_BI    = 16'(1) << CB_BI;
  localparam logic [15:0] C_OI    = 16'(1) << CB_OI;
  localparam logic [15:0] C_CE    = 16'(1) << CB_CE;
  localparam logic [15:0] C_CO    = 16'(1) << CB_CO;
  localparam logic [15:0] C_J     = 16'(1) << CB_J;
  localparam logic [15:0] C_FI    = 16'(1) << CB_FI;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

endpackage

// File: rtl/tstate_counter.sv
// rtl/tstate_counter.sv - 3-bit T-state counter with async clear, sync return to T0 and hold
module tstate_counter
  import control_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_last,
  input  logic       i_hold,
  output logic [2:0] o_step
);

  logic [2:0] r_step;

  // Hold outranks last so a halted machine stays frozen at its current step.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_step <= T0;
    end else if (!i_hold) begin
      if (i_last || r_step >= T5) begin
        r_step <= T0;
      end else begin
        r_step <= r_step + 3'd1;
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control unit: T-state sequencing and control word decode
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [3:0]  i_opcode,
  input  logic        i_cf,
  input  logic        i_zf,
  output logic [15:0] o_ctrl,
  output logic [2:0]  o_step,
  output logic        o_halted
);

  logic [2:0]  w_step;
  logic [15:0] w_ctrl;
  logic        w_last;
  logic        w_hold;
  logic        w_take;
  logic        r_halted;

  tstate_counter u_tstate_counter (
    .i_clk  (i_clk),
    .i_clr  (i_clr),
    .i_last (w_last),
    .i_hold (w_hold),
    .o_step (w_step)
  );

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_halted <= 1'b0;
    end else if (!r_halted && w_step == T2 && i_opcode == OP_HLT) begin
      r_halted <= 1'b1;
    end
  end

  assign w_take = (i_opcode == OP_JMP) ||
                  (i_opcode == OP_JC && i_cf) ||
                  (i_opcode == OP_JZ && i_zf);

  // Opcode is only looked at from T2 on, when the instruction register drives it.
  always_comb begin
    w_ctrl = '0;
    w_last = 1'b0;
    w_hold = r_halted;
    if (r_halted) begin
      w_ctrl = C_HLT | C_IR_OA;
    end else begin
      case (w_step)
        T0: w_ctrl = C_CO | C_MI;
        T1: w_ctrl = C_RO | C_IR_WA | C_CE;
        T2, T3, T4, T5: begin
          w_ctrl = C_IR_OA;
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              case (w_step)
                T2: w_ctrl = w_ctrl | C_CO | C_MI;
                T3: w_ctrl = w_ctrl | C_RO | C_MI | C_CE;
                T4: begin
                  if (i_opcode == OP_LDA) begin
                    w_ctrl = w_ctrl | C_RO | C_AI;
                    w_last = 1'b1;
                  end else if (i_opcode == OP_STA) begin
                    w_ctrl = w_ctrl | C_AO | C_RI;
                    w_last = 1'b1;
                  end else begin
                    w_ctrl = w_ctrl | C_RO | C_BI;
                  end
                end
                default: begin
                  w_ctrl = w_ctrl | C_EO | C_AI | C_FI |
                           ((i_opcode == OP_SUB) ? C_SU : 16'h0000);
                  w_last = 1'b1;
                end
              endcase
            end
            OP_LDI: begin
              if (w_step == T2) begin
                w_ctrl = w_ctrl | C_CO | C_MI;
              end else begin
                w_ctrl = w_ctrl | C_RO | C_AI | C_CE;
                w_last = 1'b1;
              end
            end
            OP_JMP, OP_JC, OP_JZ: begin
              if (!w_take) begin
                w_ctrl = w_ctrl | C_CE;
                w_last = 1'b1;
              end else if (w_step == T2) begin
                w_ctrl = w_ctrl | C_CO | C_MI;
              end else begin
                w_ctrl = w_ctrl | C_RO | C_J;
                w_last = 1'b1;
              end
            end
            OP_OUT: begin
              w_ctrl = w_ctrl | C_AO | C_OI;
              w_last = 1'b1;
            end
            OP_HLT: begin
              w_ctrl = w_ctrl | C_HLT;
              w_hold = 1'b1;
            end
            default: w_last = 1'b1;
          endcase
        end
        default: w_last = 1'b1;
      endcase
    end
  end

  assign o_ctrl   = i_clr ? 16'h0000 : w_ctrl;
  assign o_step   = w_step;
  assign o_halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed scoreboard bench for control_sequencer
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IRWA = 16'h0800, IROA = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE = 16'h0008, CO = 16'h0004, J = 16'h0002, FI = 16'h0001;

  logic        clk, clr, cf, zf;
  logic [3:0]  opcode;
  logic [15:0] o_ctrl;
  logic [2:0]  o_step;
  logic        o_halted;

  int n_assert = 0;
  int n_fail   = 0;
  logic [19:0] sb[$];

  control_sequencer dut (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_opcode (opcode),
    .i_cf     (cf),
    .i_zf     (zf),
    .o_ctrl   (o_ctrl),
    .o_step   (o_step),
    .o_halted (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ent(input logic h, input logic [2:0] s, input logic [15:0] c);
    return {h, s, c};
  endfunction

  task automatic push_seq(input logic [3:0] op, input logic c, input logic z);
    sb.push_back(ent(1'b0, 3'd0, CO | MI));
    sb.push_back(ent(1'b0, 3'd1, RO | IRWA | CE));
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        sb.push_back(ent(1'b0, 3'd2, IROA | CO | MI));
        sb.push_back(ent(1'b0, 3'd3, IROA | RO | MI | CE));
        if (op == 4'h1) sb.push_back(ent(1'b0, 3'd4, IROA | RO | AI));
        else if (op == 4'h4) sb.push_back(ent(1'b0, 3'd4, IROA | AO | RI));
        else begin
          sb.push_back(ent(1'b0, 3'd4, IROA | RO | BI));
          sb.push_back(ent(1'b0, 3'd5, IROA | EO | AI | FI | (op == 4'h3 ? SU : 16'h0)));
        end
      end
      4'h5: begin
        sb.push_back(ent(1'b0, 3'd2, IROA | CO | MI));
        sb.push_back(ent(1'b0, 3'd3, IROA | RO | AI | CE));
      end
      4'h6, 4'h7, 4'h8: begin
        if (op == 4'h6 || (op == 4'h7 && c) || (op == 4'h8 && z)) begin
          sb.push_back(ent(1'b0, 3'd2, IROA | CO | MI));
          sb.push_back(ent(1'b0, 3'd3, IROA | RO | J));
        end else begin
          sb.push_back(ent(1'b0, 3'd2, IROA | CE));
        end
      end
      4'hE: sb.push_back(ent(1'b0, 3'd2, IROA | AO | OI));
      4'hF: sb.push_back(ent(1'b0, 3'd2, IROA | HLT));
      default: sb.push_back(ent(1'b0, 3'd2, IROA));
    endcase
  endtask

  task automatic sample_one(input string tag);
    logic [19:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end else begin
      e = sb.pop_front();
      chk({tag, "_step"}, {13'h0, o_step}, {13'h0, e[18:16]});
      chk({tag, "_ctrl"}, o_ctrl, e[15:0]);
      chk({tag, "_halted"}, {15'h0, o_halted}, {15'h0, e[19]});
    end
  endtask

  // n_chk > 0 stops after that many steps, leaving the instruction mid-flight.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic c,
                           input logic z, input int n_chk);
    int n;
    push_seq(op, c, z);
    n = sb.size();
    if (n_chk > 0 && n_chk < n) n = n_chk;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op;
        cf = c;
        zf = z;
      end
      #1;
      sample_one(tag);
    end
    sb.delete();
  endtask

  initial begin
    clr = 1'b1;
    opcode = 4'hF;
    cf = 1'b0;
    zf = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("rst_ctrl", o_ctrl, 16'h0000);
      chk("rst_step", {13'h0, o_step}, 16'h0000);
      chk("rst_halted", {15'h0, o_halted}, 16'h0000);
    end
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("rel_ctrl", o_ctrl, CO | MI);
    chk("rel_step", {13'h0, o_step}, 16'h0000);

    run_instr("lda", 4'h1, 1'b0, 1'b0, 0);
    run_instr("sub", 4'h3, 1'b0, 1'b0, 0);
    run_instr("add", 4'h2, 1'b0, 1'b0, 0);
    run_instr("jc_n", 4'h7, 1'b0, 1'b1, 0);
    run_instr("jc_t", 4'h7, 1'b1, 1'b0, 0);
    run_instr("jz_n", 4'h8, 1'b1, 1'b0, 0);
    run_instr("jz_t", 4'h8, 1'b0, 1'b1, 0);
    run_instr("sta", 4'h4, 1'b0, 1'b0, 0);
    run_instr("ldi", 4'h5, 1'b0, 1'b0, 0);
    run_instr("jmp", 4'h6, 1'b0, 1'b0, 0);
    run_instr("out", 4'hE, 1'b0, 1'b0, 0);
    run_instr("nop_a", 4'hA, 1'b0, 1'b0, 0);
    run_instr("nop", 4'h0, 1'b0, 1'b0, 0);

    run_instr("add_abort", 4'h2, 1'b0, 1'b0, 5);
    #2 clr = 1'b1;
    #1;
    chk("abort_ctrl", o_ctrl, 16'h0000);
    chk("abort_step", {13'h0, o_step}, 16'h0000);
    @(negedge clk);
    #1;
    chk("abort_hold_ctrl", o_ctrl, 16'h0000);
    chk("abort_hold_step", {13'h0, o_step}, 16'h0000);
    @(posedge clk);
    #1 clr = 1'b0;
    run_instr("add_restart", 4'h2, 1'b0, 1'b0, 0);

    run_instr("hlt", 4'hF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) sb.push_back(ent(1'b1, 3'd2, HLT | IROA));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      sample_one("halted");
    end
    clr = 1'b1;
    #1;
    chk("hclr_ctrl", o_ctrl, 16'h0000);
    chk("hclr_step", {13'h0, o_step}, 16'h0000);
    chk("hclr_halted", {15'h0, o_halted}, 16'h0000);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("hrel_ctrl", o_ctrl, CO | MI);
    run_instr("post_hlt", 4'h5, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
